// File: rtl/mips_mc_controller_if.sv
// mips_mc_controller_if: instruction fields, memory handshake, datapath controls and status
// bundled between the multicycle controller (master) and the datapath/memory side (slave).
interface mips_mc_controller_if #(
    parameter int CNT_W = 32
);
    logic [5:0] op;
    logic [5:0] funct;
    logic zero;
    logic mem_ready;
    logic mem_req;
    logic MemWrite;
    logic IorD;
    logic IRWrite;
    logic PCWrite;
    logic PCWriteCond;
    logic [1:0] PCSource;
    logic ALUSrcA;
    logic [2:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic RegWrite;
    logic illegal_instr;
    logic bus_error;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;
    modport master (
        input op, funct, zero, mem_ready,
        output mem_req, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, ALUSrcA, ALUSrcB,
        output ALUOp, RegDst, MemtoReg, RegWrite, illegal_instr, bus_error, cycle_count, instr_count
    );
    modport slave (
        output op, funct, zero, mem_ready,
        input mem_req, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, ALUSrcA, ALUSrcB,
        input ALUOp, RegDst, MemtoReg, RegWrite, illegal_instr, bus_error, cycle_count, instr_count
    );
endinterface

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle MIPS main control FSM with variable-latency memory handshake,
// memory-timeout watchdog, illegal-opcode trap and saturating cycle/instruction counters.
module mips_mc_controller #(
    parameter int CNT_W = 32,
    parameter int TIMEOUT = 255,
    parameter bit EN_JAL_JR = 1'b1
) (
    input logic clk,
    input logic rst,
    mips_mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE,
        ALUWB, IMMEX, IMMWB, BRANCH, JUMP, JAL, JR, TRAP
    } state_t;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
    state_t state_q, state_d;
    logic [15:0] wd_q, wd_d;
    logic illegal_q, illegal_d, bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d;
    logic waiting, timeout;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wd_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            state_q <= state_d;
            wd_q <= wd_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            cyc_q <= cyc_d;
            ins_q <= ins_d;
        end
    end
    always_comb begin
        waiting = (state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !bus.mem_ready;
        timeout = waiting && wd_q == WD_LAST;
        wd_d = (waiting && !timeout) ? wd_q + 16'd1 : '0;
        cyc_d = &cyc_q ? cyc_q : cyc_q + CNT_W'(1);
        ins_d = (state_q == FETCH && bus.mem_ready && ~&ins_q) ? ins_q + CNT_W'(1) : ins_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        state_d = state_q;
        bus.mem_req = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IorD = 1'b0;
        bus.IRWrite = 1'b0;
        bus.PCWrite = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.PCSource = 2'b00;
        bus.ALUSrcA = 1'b0;
        bus.ALUSrcB = 3'b000;
        bus.ALUOp = 2'b00;
        bus.RegDst = 2'b00;
        bus.MemtoReg = 2'b00;
        bus.RegWrite = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                bus.mem_req = 1'b1;
                bus.ALUSrcB = 3'b001;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
                state_d = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.ALUSrcB = 3'b011;
                case (bus.op)
                    6'b000000: state_d = (bus.funct != 6'b001000) ? RTYPE : (EN_JAL_JR ? JR : TRAP);
                    6'b100011, 6'b101011: state_d = MEMADR;
                    6'b000100, 6'b000101: state_d = BRANCH;
                    6'b001000, 6'b001100, 6'b001101, 6'b001010: state_d = IMMEX;
                    6'b000010: state_d = JUMP;
                    6'b000011: state_d = EN_JAL_JR ? JAL : TRAP;
                    default: state_d = TRAP;
                endcase
                illegal_d = illegal_q | (state_d == TRAP);
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 3'b010;
                state_d = (bus.op == 6'b101011) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.IorD = 1'b1;
                state_d = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                bus.MemtoReg = 2'b01;
                bus.RegWrite = 1'b1;
                state_d = FETCH;
            end
            MEMWR: begin
                bus.mem_req = 1'b1;
                bus.MemWrite = 1'b1;
                bus.IorD = 1'b1;
                state_d = bus.mem_ready ? FETCH : MEMWR;
            end
            RTYPE: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                bus.RegDst = 2'b01;
                bus.RegWrite = 1'b1;
                state_d = FETCH;
            end
            IMMEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp = 2'b11;
                // andi/ori take a zero-extended immediate; addi/slti sign-extend
                bus.ALUSrcB = (bus.op == 6'b001100 || bus.op == 6'b001101) ? 3'b100 : 3'b010;
                state_d = IMMWB;
            end
            IMMWB: begin
                bus.RegWrite = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp = 2'b01;
                bus.PCSource = 2'b01;
                bus.PCWriteCond = bus.zero ^ (bus.op == 6'b000101);
                state_d = FETCH;
            end
            JUMP: begin
                bus.PCSource = 2'b10;
                bus.PCWrite = 1'b1;
                state_d = FETCH;
            end
            JAL: begin
                bus.PCSource = 2'b10;
                bus.PCWrite = 1'b1;
                bus.RegDst = 2'b10;
                bus.MemtoReg = 2'b10;
                bus.RegWrite = 1'b1;
                state_d = FETCH;
            end
            JR: begin
                bus.PCSource = 2'b11;
                bus.PCWrite = 1'b1;
                state_d = FETCH;
            end
            default: ;
        endcase
        if (timeout) begin
            state_d = TRAP;
            bus_err_d = 1'b1;
        end
    end
    assign bus.illegal_instr = illegal_q;
    assign bus.bus_error = bus_err_q;
    assign bus.cycle_count = cyc_q;
    assign bus.instr_count = ins_q;
endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: directed checks of control outputs per state, memory wait/timeout,
// branch polarity, traps, async reset and counter saturation.
module tb_mips_mc_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_b = 1'b0;
    int total = 0;
    int bad = 0;
    mips_mc_controller_if #(.CNT_W(4)) ifa ();
    mips_mc_controller_if #(.CNT_W(8)) ifb ();
    mips_mc_controller #(.CNT_W(4), .TIMEOUT(4), .EN_JAL_JR(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    mips_mc_controller #(.CNT_W(8), .TIMEOUT(255), .EN_JAL_JR(1'b0)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.master));
    always #5 clk = ~clk;
    // {mem_req,MemWrite,IorD,IRWrite,PCWrite,PCWriteCond,PCSource,ALUSrcA,ALUSrcB,ALUOp,RegDst,MemtoReg,RegWrite}
    logic [18:0] ctl_a, ctl_b;
    assign ctl_a = {ifa.mem_req, ifa.MemWrite, ifa.IorD, ifa.IRWrite, ifa.PCWrite, ifa.PCWriteCond, ifa.PCSource,
                    ifa.ALUSrcA, ifa.ALUSrcB, ifa.ALUOp, ifa.RegDst, ifa.MemtoReg, ifa.RegWrite};
    assign ctl_b = {ifb.mem_req, ifb.MemWrite, ifb.IorD, ifb.IRWrite, ifb.PCWrite, ifb.PCWriteCond, ifb.PCSource,
                    ifb.ALUSrcA, ifb.ALUSrcB, ifb.ALUOp, ifb.RegDst, ifb.MemtoReg, ifb.RegWrite};
    localparam logic [18:0] F_RDY  = 19'b1_0_0_1_1_0_00_0_001_00_00_00_0;
    localparam logic [18:0] F_WAIT = 19'b1_0_0_0_0_0_00_0_001_00_00_00_0;
    localparam logic [18:0] DEC    = 19'b0_0_0_0_0_0_00_0_011_00_00_00_0;
    localparam logic [18:0] MADR   = 19'b0_0_0_0_0_0_00_1_010_00_00_00_0;
    localparam logic [18:0] MRD    = 19'b1_0_1_0_0_0_00_0_000_00_00_00_0;
    localparam logic [18:0] MWB    = 19'b0_0_0_0_0_0_00_0_000_00_00_01_1;
    localparam logic [18:0] MWR    = 19'b1_1_1_0_0_0_00_0_000_00_00_00_0;
    localparam logic [18:0] RTY    = 19'b0_0_0_0_0_0_00_1_000_10_00_00_0;
    localparam logic [18:0] AWB    = 19'b0_0_0_0_0_0_00_0_000_00_01_00_1;
    localparam logic [18:0] IMX    = 19'b0_0_0_0_0_0_00_1_100_11_00_00_0;
    localparam logic [18:0] IWB    = 19'b0_0_0_0_0_0_00_0_000_00_00_00_1;
    localparam logic [18:0] BR_T   = 19'b0_0_0_0_0_1_01_1_000_01_00_00_0;
    localparam logic [18:0] BR_N   = 19'b0_0_0_0_0_0_01_1_000_01_00_00_0;
    localparam logic [18:0] JMP    = 19'b0_0_0_0_1_0_10_0_000_00_00_00_0;
    localparam logic [18:0] JL     = 19'b0_0_0_0_1_0_10_0_000_00_10_10_1;
    localparam logic [18:0] JRR    = 19'b0_0_0_0_1_0_11_0_000_00_00_00_0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        ifa.op = '0; ifa.funct = '0; ifa.zero = 1'b0; ifa.mem_ready = 1'b0;
        ifb.op = '0; ifb.funct = '0; ifb.zero = 1'b0; ifb.mem_ready = 1'b0;
        #12;
        chk("rst_ctl", 32'(ctl_a), 0);
        chk("rst_cyc", 32'(ifa.cycle_count), 0);
        chk("rst_icnt", 32'(ifa.instr_count), 0);
        chk("rst_flags", {30'd0, ifa.illegal_instr, ifa.bus_error}, 0);
        rst = 1'b1;
        step(1);
        chk("cyc_first", 32'(ifa.cycle_count), 1);
        ifa.mem_ready = 1'b1; ifa.op = 6'b100011; #1;
        chk("lw_fetch", 32'(ctl_a), 32'(F_RDY));
        step(1); chk("lw_dec", 32'(ctl_a), 32'(DEC)); chk("lw_icnt", 32'(ifa.instr_count), 1);
        step(1); chk("lw_madr", 32'(ctl_a), 32'(MADR));
        step(1); chk("lw_mrd", 32'(ctl_a), 32'(MRD));
        step(1); chk("lw_mwb", 32'(ctl_a), 32'(MWB)); chk("lw_cyc", 32'(ifa.cycle_count), 5);
        step(1);
        ifa.mem_ready = 1'b0; ifa.op = 6'b000100; ifa.zero = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            chk("fwait_ctl", 32'(ctl_a), 32'(F_WAIT));
            step(1);
        end
        ifa.mem_ready = 1'b1; #1;
        chk("fwait_rdy", 32'(ctl_a), 32'(F_RDY));
        chk("fwait_icnt_hold", 32'(ifa.instr_count), 1);
        step(1); chk("fwait_icnt_inc", 32'(ifa.instr_count), 2);
        step(1); chk("beq_z1", 32'(ctl_a), 32'(BR_T));
        step(1);
        ifa.op = 6'b000101;
        step(2); chk("bne_z1", 32'(ctl_a), 32'(BR_N));
        ifa.zero = 1'b0; #1; chk("bne_z0", 32'(ctl_a), 32'(BR_T));
        step(1);
        ifa.op = 6'b000011;
        step(2); chk("jal", 32'(ctl_a), 32'(JL));
        step(1);
        ifa.op = 6'b000000; ifa.funct = 6'b001000;
        step(2); chk("jr", 32'(ctl_a), 32'(JRR));
        step(1);
        ifa.op = 6'b101011;
        step(3);
        ifa.mem_ready = 1'b0; #1; chk("sw_wait", 32'(ctl_a), 32'(MWR));
        step(1); chk("sw_hold", 32'(ctl_a), 32'(MWR));
        ifa.mem_ready = 1'b1;
        step(1); chk("sw_done", 32'(ctl_a), 32'(F_RDY));
        ifa.op = 6'b001101;
        step(2); chk("ori_ex", 32'(ctl_a), 32'(IMX));
        step(1); chk("ori_wb", 32'(ctl_a), 32'(IWB));
        step(1);
        ifa.op = 6'b000000; ifa.funct = 6'b100000;
        step(2); chk("rtype_ex", 32'(ctl_a), 32'(RTY));
        step(1); chk("rtype_wb", 32'(ctl_a), 32'(AWB));
        step(1);
        ifa.op = 6'b111111;
        step(2);
        chk("ill_ctl", 32'(ctl_a), 0);
        chk("ill_flags", {30'd0, ifa.illegal_instr, ifa.bus_error}, 2);
        chk("ill_icnt", 32'(ifa.instr_count), 9);
        step(3); chk("trap_stay", 32'(ctl_a), 0);
        rst = 1'b0; #1;
        chk("rst_clr_flags", {30'd0, ifa.illegal_instr, ifa.bus_error}, 0);
        rst = 1'b1; ifa.mem_ready = 1'b0; ifa.op = 6'b100011;
        step(1); chk("to_wait1", 32'(ctl_a), 32'(F_WAIT));
        step(3); chk("to_wait4", 32'(ctl_a), 32'(F_WAIT));
        chk("to_noerr_yet", {31'd0, ifa.bus_error}, 0);
        step(1); chk("to_trap_ctl", 32'(ctl_a), 0);
        chk("to_flags", {30'd0, ifa.illegal_instr, ifa.bus_error}, 1);
        rst = 1'b0; #1; rst = 1'b1;
        step(1); chk("mid_req", {31'd0, ifa.mem_req}, 1);
        #3; rst = 1'b0; #1;
        chk("async_drop", {31'd0, ifa.mem_req}, 0);
        chk("async_cnt", 32'(ifa.cycle_count), 0);
        rst = 1'b1; ifa.op = 6'b000010; ifa.mem_ready = 1'b1;
        step(1);
        for (int i = 0; i < 15; i++) begin
            step(2);
            if (i == 0) chk("jump", 32'(ctl_a), 32'(JMP));
            step(1);
        end
        chk("sat_icnt", 32'(ifa.instr_count), 15);
        chk("sat_cyc", 32'(ifa.cycle_count), 15);
        step(1);
        chk("sat_icnt_hold", 32'(ifa.instr_count), 15);
        chk("sat_cyc_hold", 32'(ifa.cycle_count), 15);
        ifb.mem_ready = 1'b1; ifb.op = 6'b000011; rst_b = 1'b1;
        step(3);
        chk("b_jal_trap_ctl", 32'(ctl_b), 0);
        chk("b_jal_flags", {30'd0, ifb.illegal_instr, ifb.bus_error}, 2);
        chk("b_cyc", 32'(ifb.cycle_count), 3);
        chk("b_icnt", 32'(ifb.instr_count), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
